// File: rtl/roundkey_rev_buffer.sv
// roundkey_rev_buffer: holds the expanded AES key schedule (NUM_ROUNDS+1 round
// keys) written in forward order by key expansion. It serves the keys in reverse
// order, from round NUM_ROUNDS down to 0, to the inverse-round datapath.
// The schedule stays in place after a read-out, so later blocks can reuse it.
// Optional build macro ROUNDKEY_ZEROIZE_EN: after reset or clear, the block
// zeroes every stored key, one entry per cycle, before it accepts a new load.
module roundkey_rev_buffer #(
    parameter int NUM_ROUNDS = 10
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [3:0][3:0][7:0]  key_in,
    input  logic                  key_in_valid,
    output logic                  key_in_ready,
    input  logic                  clear,
    input  logic                  dec_start,
    output logic [3:0][3:0][7:0]  key_out,
    output logic                  key_out_valid,
    input  logic                  key_out_ready,
    output logic [3:0]            round_idx,
    output logic                  last_key,
    output logic                  loaded
);
    localparam int NK = NUM_ROUNDS + 1;
    localparam int PW = $clog2(NK);
    localparam logic [PW-1:0] LAST = PW'(NUM_ROUNDS);

`ifdef ROUNDKEY_ZEROIZE_EN
    typedef enum logic [1:0] {S_LOAD, S_LOADED, S_SERVE, S_WIPE} state_t;
    localparam state_t S_INIT = S_WIPE;
`else
    typedef enum logic [1:0] {S_LOAD, S_LOADED, S_SERVE} state_t;
    localparam state_t S_INIT = S_LOAD;
`endif

    state_t state, state_nxt;

    logic [3:0][3:0][7:0] mem [NK];
    logic [PW-1:0]        wr_ptr;
    logic [PW-1:0]        rd_ptr;
`ifdef ROUNDKEY_ZEROIZE_EN
    logic [PW-1:0]        wipe_ptr;
`endif

    // A write or read handshake that coincides with clear is dropped.
    logic wr_en, rd_hs, rd_dec, serve_go;
    assign wr_en    = (state == S_LOAD) && key_in_valid && !clear;
    assign rd_hs    = (state == S_SERVE) && key_out_ready && !clear;
    assign rd_dec   = rd_hs && (rd_ptr != '0);
    assign serve_go = (state == S_LOADED) && dec_start && !clear;

    // State register
    always_ff @(posedge clk or posedge rst) begin
        if (rst) state <= S_INIT;
        else     state <= state_nxt;
    end

    // Next-state logic; clear outranks every other transition
    always_comb begin
        state_nxt = state;
        if (clear) begin
            state_nxt = S_INIT;
        end else begin
            case (state)
                S_LOAD:   if (key_in_valid && wr_ptr == LAST) state_nxt = S_LOADED;
                S_LOADED: if (dec_start) state_nxt = S_SERVE;
                S_SERVE:  if (key_out_ready && rd_ptr == '0) state_nxt = S_LOADED;
`ifdef ROUNDKEY_ZEROIZE_EN
                S_WIPE:   if (wipe_ptr == LAST) state_nxt = S_LOAD;
`endif
                default:  state_nxt = S_INIT;
            endcase
        end
    end

    // Write, read and wipe pointers; reset and clear both rewind them to 0
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr   <= '0;
            rd_ptr   <= '0;
`ifdef ROUNDKEY_ZEROIZE_EN
            wipe_ptr <= '0;
`endif
        end else if (clear) begin
            wr_ptr   <= '0;
            rd_ptr   <= '0;
`ifdef ROUNDKEY_ZEROIZE_EN
            wipe_ptr <= '0;
`endif
        end else begin
            if (wr_en) wr_ptr <= wr_ptr + 1'b1;
            if (serve_go)    rd_ptr <= LAST;
            else if (rd_dec) rd_ptr <= rd_ptr - 1'b1;
`ifdef ROUNDKEY_ZEROIZE_EN
            if (state == S_WIPE) wipe_ptr <= wipe_ptr + 1'b1;
`endif
        end
    end

    // Key storage, deliberately not reset; a wipe zeroes one entry per cycle
    always_ff @(posedge clk) begin
        if (wr_en) mem[wr_ptr] <= key_in;
`ifdef ROUNDKEY_ZEROIZE_EN
        else if (state == S_WIPE) mem[wipe_ptr] <= '0;
`endif
    end

    // Outputs are decoded from state only, so an async reset clears them at once
    always_comb begin
        key_in_ready  = 1'b0;
        key_out_valid = 1'b0;
        key_out       = '0;
        round_idx     = '0;
        last_key      = 1'b0;
        loaded        = 1'b0;
        case (state)
            S_LOAD:   key_in_ready = 1'b1;
            S_LOADED: loaded = 1'b1;
            S_SERVE: begin
                loaded        = 1'b1;
                key_out_valid = 1'b1;
                key_out       = mem[rd_ptr];
                round_idx     = 4'(rd_ptr);
                last_key      = (rd_ptr == '0);
            end
            default: ;
        endcase
    end

endmodule

// File: tb/tb_roundkey_rev_buffer.sv
// Directed bench for roundkey_rev_buffer. Read-out sequences come from a vector
// table of {ready, expected outputs}. Short hand-written sequences cover clear,
// async reset and the optional zeroize build.
module tb_roundkey_rev_buffer;
    logic                 clk = 1'b0;
    logic                 rst = 1'b1;
    logic [3:0][3:0][7:0] key_in = '0;
    logic                 key_in_valid = 1'b0;
    logic                 key_in_ready;
    logic                 clear = 1'b0;
    logic                 dec_start = 1'b0;
    logic [3:0][3:0][7:0] key_out;
    logic                 key_out_valid;
    logic                 key_out_ready = 1'b0;
    logic [3:0]           round_idx;
    logic                 last_key;
    logic                 loaded;

    int errors = 0;
    int checks = 0;

    roundkey_rev_buffer #(.NUM_ROUNDS(10)) dut (
        .clk(clk), .rst(rst),
        .key_in(key_in), .key_in_valid(key_in_valid), .key_in_ready(key_in_ready),
        .clear(clear), .dec_start(dec_start),
        .key_out(key_out), .key_out_valid(key_out_valid), .key_out_ready(key_out_ready),
        .round_idx(round_idx), .last_key(last_key), .loaded(loaded)
    );

    always #5 clk = ~clk;

    typedef struct {
        bit rdy;   // key_out_ready applied this cycle
        bit ev;    // expected key_out_valid
        int eidx;  // expected round_idx (and key number)
        bit elast; // expected last_key
    } vec_t;

    vec_t tab[$];

`ifdef ROUNDKEY_ZEROIZE_EN
    localparam bit ZEROIZE = 1'b1;
`else
    localparam bit ZEROIZE = 1'b0;
`endif

    // Key i: byte j = 0x10*i + j, xored with a per-load tag to tell loads apart
    function automatic logic [127:0] kpat(input int i, input logic [7:0] x);
        logic [127:0] r;
        for (int j = 0; j < 16; j++) r[8*j +: 8] = 8'(16*i + j) ^ x;
        return r;
    endfunction

    task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Write keys 0..n-1 back-to-back; optionally raise dec_start on the last write
    task automatic load_keys(input int n, input logic [7:0] x, input bit ds_last);
        for (int i = 0; i < n; i++) begin
            key_in       = kpat(i, x);
            key_in_valid = 1'b1;
            dec_start    = ds_last && (i == n - 1);
            step();
        end
        key_in_valid = 1'b0;
        dec_start    = 1'b0;
    endtask

    // After reset or clear in the zeroize build, key_in_ready stays low for 11 cycles
    task automatic wipe_wait();
        if (ZEROIZE) begin
            for (int k = 0; k < 11; k++) begin
                chk("wipe_ready_low", 128'(key_in_ready), 128'(0));
                chk("wipe_loaded_low", 128'(loaded), 128'(0));
                step();
            end
        end
        chk("ready_after_wipe", 128'(key_in_ready), 128'(1));
    endtask

    // Build a read-out table: mode 0 holds ready high; mode 1 uses ready 1,0,0,...
    task automatic build_tab(input int mode);
        int  cur;
        int  k;
        bit  done;
        bit  r;
        tab.delete();
        cur  = 10;
        k    = 0;
        done = 1'b0;
        while (!done) begin
            r = (mode == 0) ? 1'b1 : (k % 3 == 0);
            tab.push_back('{rdy: r, ev: 1'b1, eidx: cur, elast: (cur == 0)});
            if (r) begin
                if (cur == 0) done = 1'b1;
                else          cur--;
            end
            k++;
        end
        tab.push_back('{rdy: 1'b0, ev: 1'b0, eidx: 0, elast: 1'b0});
    endtask

    // Pulse dec_start, then apply the table; ds_hold keeps dec_start high during SERVE
    task automatic serve(input logic [7:0] x, input bit ds_hold);
        dec_start = 1'b1;
        chk("valid_before_latency", 128'(key_out_valid), 128'(0));
        step();
        dec_start = 1'b0;
        foreach (tab[n]) begin
            key_out_ready = tab[n].rdy;
            dec_start     = ds_hold && tab[n].ev;
            chk("serve_valid", 128'(key_out_valid), 128'(tab[n].ev));
            chk("serve_idx", 128'(round_idx), 128'(tab[n].eidx));
            chk("serve_key", key_out, tab[n].ev ? kpat(tab[n].eidx, x) : 128'(0));
            chk("serve_last", 128'(last_key), 128'(tab[n].elast));
            step();
        end
        key_out_ready = 1'b0;
        dec_start     = 1'b0;
    endtask

    initial begin
        // Reset state
        #2;
        chk("rst_ready", 128'(key_in_ready), 128'(!ZEROIZE));
        chk("rst_valid", 128'(key_out_valid), 128'(0));
        chk("rst_key", key_out, 128'(0));
        chk("rst_idx", 128'(round_idx), 128'(0));
        chk("rst_last", 128'(last_key), 128'(0));
        chk("rst_loaded", 128'(loaded), 128'(0));
        step();
        rst = 1'b0;
        wipe_wait();

        // Full load. dec_start on the final write is ignored because the block is still in LOAD
        load_keys(10, 8'h00, 1'b0);
        chk("loaded_after_10", 128'(loaded), 128'(0));
        load_keys(1, 8'h00, 1'b0);
        chk("loaded_after_11", 128'(loaded), 128'(1));
        chk("ready_after_11", 128'(key_in_ready), 128'(0));
        chk("no_serve_yet", 128'(key_out_valid), 128'(0));
        rst = 1'b1; #1; rst = 1'b0;
        wipe_wait();
        load_keys(11, 8'h00, 1'b1);
        chk("ds_on_last_write_loaded", 128'(loaded), 128'(1));
        chk("ds_on_last_write_ignored", 128'(key_out_valid), 128'(0));
        step();
        chk("ds_on_last_write_still_idle", 128'(key_out_valid), 128'(0));

        // Read-out with ready held high, then a reuse with no reload, then toggled ready with dec_start held
        build_tab(0);
        serve(8'h00, 1'b0);
        serve(8'h00, 1'b0);
        build_tab(1);
        serve(8'h00, 1'b1);
        chk("back_to_loaded", 128'(loaded), 128'(1));

        // clear in the middle of a load (after 5 keys) drops the coinciding write
        clear = 1'b1;
        step();
        clear = 1'b0;
        wipe_wait();
        load_keys(5, 8'h33, 1'b0);
        key_in = kpat(5, 8'h33); key_in_valid = 1'b1; clear = 1'b1;
        step();
        clear = 1'b0; key_in_valid = 1'b0;
        chk("clr_load_loaded", 128'(loaded), 128'(0));
        chk("clr_load_valid", 128'(key_out_valid), 128'(0));
        wipe_wait();
        dec_start = 1'b1;
        step();
        dec_start = 1'b0;
        chk("clr_load_ds_ignored", 128'(key_out_valid), 128'(0));

        // clear in the middle of a serve (round_idx==6), with a handshake on the same cycle
        load_keys(11, 8'h5A, 1'b0);
        dec_start = 1'b1;
        step();
        dec_start = 1'b0;
        key_out_ready = 1'b1;
        repeat (4) step();
        chk("mid_serve_idx6", 128'(round_idx), 128'(6));
        chk("mid_serve_key6", key_out, kpat(6, 8'h5A));
        clear = 1'b1;
        step();
        clear = 1'b0; key_out_ready = 1'b0;
        chk("clr_serve_loaded", 128'(loaded), 128'(0));
        chk("clr_serve_valid", 128'(key_out_valid), 128'(0));
        chk("clr_serve_idx", 128'(round_idx), 128'(0));
        wipe_wait();
        load_keys(11, 8'hA5, 1'b0);
        build_tab(0);
        serve(8'hA5, 1'b0);

        // Async reset between clock edges during a serve
        dec_start = 1'b1;
        step();
        dec_start = 1'b0;
        key_out_ready = 1'b1;
        step();
        chk("pre_rst_idx9", 128'(round_idx), 128'(9));
        #2 rst = 1'b1;
        #1;
        chk("arst_valid", 128'(key_out_valid), 128'(0));
        chk("arst_key", key_out, 128'(0));
        chk("arst_idx", 128'(round_idx), 128'(0));
        chk("arst_loaded", 128'(loaded), 128'(0));
        #2 rst = 1'b0;
        key_out_ready = 1'b0;
        wipe_wait();
        dec_start = 1'b1;
        step();
        dec_start = 1'b0;
        chk("arst_ds_ignored", 128'(key_out_valid), 128'(0));
        chk("arst_ds_ready", 128'(key_in_ready), 128'(1));

`ifdef ROUNDKEY_ZEROIZE_EN
        // Zeroize: a full load, a clear, then a partial reload. Entry 10 must read back as zero.
        load_keys(11, 8'h00, 1'b0);
        clear = 1'b1;
        step();
        clear = 1'b0;
        wipe_wait();
        load_keys(10, 8'h00, 1'b0);
        chk("zero_loaded_low", 128'(loaded), 128'(0));
        dec_start = 1'b1;
        step();
        dec_start = 1'b0;
        chk("zero_ds_ignored", 128'(key_out_valid), 128'(0));
        chk("zero_mem10", dut.mem[10], 128'(0));
        chk("zero_mem9_kept", dut.mem[9], kpat(9, 8'h00));
`endif

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
